// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - two-source (I$/D$) miss arbiter in front of a single main-memory port
//
// Purpose:
//   Holds one pending miss per cache, grants one at a time to main memory,
//   waits LATENCY_REQ cycles, issues the request until memory responds, then
//   returns a one-cycle response tagged with the requesting cache. D$ is
//   preferred, but only MAX_DCACHE_GRANTS times in a row while I$ is waiting.
//
// Request info layout (packed): {addr[ADDR_WIDTH-1:0], is_store, data[LINE_WIDTH-1:0]}
//
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   icache_req_valid_i/info_i   I$ miss pulse and request info
//   dcache_req_valid_i/info_i   D$ miss pulse and request info
//   mm_req_valid_o/info_o       request to main memory, held until response
//   mm_rsp_valid_i              one-cycle memory response pulse
//   mm_rsp_data_i               memory response line
//   mm_rsp_bus_error_i          bus error, qualified by mm_rsp_valid_i
//   rsp_valid_o                 one-cycle response to the core
//   rsp_cache_id_o              0 = I$, 1 = D$
//   rsp_data_o                  response line
//   rsp_bus_error_o             bus error for this response

`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 128
`endif

module mem_req_arbiter #(
  parameter int LATENCY_REQ       = 2,
  parameter int LINE_WIDTH        = `DCACHE_LINE_WIDTH,
  parameter int MAX_DCACHE_GRANTS = 4,
  parameter int ADDR_WIDTH        = 32,
  localparam int REQ_WIDTH        = ADDR_WIDTH + 1 + LINE_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  icache_req_valid_i,
  input  logic [REQ_WIDTH-1:0]  icache_req_info_i,
  input  logic                  dcache_req_valid_i,
  input  logic [REQ_WIDTH-1:0]  dcache_req_info_i,
  output logic                  mm_req_valid_o,
  output logic [REQ_WIDTH-1:0]  mm_req_info_o,
  input  logic                  mm_rsp_valid_i,
  input  logic [LINE_WIDTH-1:0] mm_rsp_data_i,
  input  logic                  mm_rsp_bus_error_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_cache_id_o,
  output logic [LINE_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_bus_error_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LAT   = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int              LCW      = (LATENCY_REQ > 1) ? $clog2(LATENCY_REQ) : 1;
  localparam logic [LCW-1:0]  LAT_LAST = LCW'(LATENCY_REQ - 1);
  localparam int              GCW      = $clog2(MAX_DCACHE_GRANTS + 1);
  localparam logic [GCW-1:0]  GNT_MAX  = GCW'(MAX_DCACHE_GRANTS);

  logic [1:0]            state_q, state_d;
  logic                  pend_i_q, pend_i_d;
  logic                  pend_d_q, pend_d_d;
  logic [REQ_WIDTH-1:0]  info_i_q, info_i_d;
  logic [REQ_WIDTH-1:0]  info_d_q, info_d_d;
  logic                  grant_q, grant_d;        // 1 = D$ owns the current transaction
  logic [LCW-1:0]        lat_cnt_q, lat_cnt_d;
  logic [GCW-1:0]        dgrant_cnt_q, dgrant_cnt_d;
  logic [REQ_WIDTH-1:0]  mm_req_info_q, mm_req_info_d;
  logic                  rsp_cache_id_q, rsp_cache_id_d;
  logic [LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_bus_error_q, rsp_bus_error_d;

  logic in_resp;
  logic acc_i;
  logic acc_d;

  always_comb begin
    state_d         = state_q;
    pend_i_d        = pend_i_q;
    pend_d_d        = pend_d_q;
    info_i_d        = info_i_q;
    info_d_d        = info_d_q;
    grant_d         = grant_q;
    lat_cnt_d       = lat_cnt_q;
    dgrant_cnt_d    = dgrant_cnt_q;
    mm_req_info_d   = mm_req_info_q;
    rsp_cache_id_d  = rsp_cache_id_q;
    rsp_data_d      = rsp_data_q;
    rsp_bus_error_d = rsp_bus_error_q;

    in_resp = (state_q == S_RESP);

    // A source with a pending miss can only post a new one in the cycle its
    // current one is being answered; the new pulse then wins over the clear.
    acc_i = icache_req_valid_i && (!pend_i_q || (in_resp && !grant_q));
    acc_d = dcache_req_valid_i && (!pend_d_q || (in_resp &&  grant_q));

    if (in_resp) begin
      if (grant_q) pend_d_d = 1'b0;
      else         pend_i_d = 1'b0;
    end
    if (acc_i) begin
      pend_i_d = 1'b1;
      info_i_d = icache_req_info_i;
    end
    if (acc_d) begin
      pend_d_d = 1'b1;
      info_d_d = dcache_req_info_i;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_i_q || pend_d_q) begin
          state_d   = S_LAT;
          lat_cnt_d = '0;
          if (pend_d_q && (!pend_i_q || dgrant_cnt_q < GNT_MAX)) begin
            grant_d = 1'b1;
            // Only back-to-back D$ wins over a waiting I$ count towards the cap;
            // the guard above keeps the increment from passing GNT_MAX.
            dgrant_cnt_d = pend_i_q ? dgrant_cnt_q + GCW'(1) : '0;
          end else begin
            grant_d      = 1'b0;
            dgrant_cnt_d = '0;
          end
        end
      end
      S_LAT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d       = S_ISSUE;
          mm_req_info_d = grant_q ? info_d_q : info_i_q;
        end else begin
          lat_cnt_d = lat_cnt_q + LCW'(1);
        end
      end
      S_ISSUE: begin
        if (mm_rsp_valid_i) begin
          state_d         = S_RESP;
          rsp_data_d      = mm_rsp_data_i;
          rsp_bus_error_d = mm_rsp_bus_error_i;
          rsp_cache_id_d  = grant_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q         <= S_IDLE;
      pend_i_q        <= 1'b0;
      pend_d_q        <= 1'b0;
      info_i_q        <= '0;
      info_d_q        <= '0;
      grant_q         <= 1'b0;
      lat_cnt_q       <= '0;
      dgrant_cnt_q    <= '0;
      mm_req_info_q   <= '0;
      rsp_cache_id_q  <= 1'b0;
      rsp_data_q      <= '0;
      rsp_bus_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_i_q        <= pend_i_d;
      pend_d_q        <= pend_d_d;
      info_i_q        <= info_i_d;
      info_d_q        <= info_d_d;
      grant_q         <= grant_d;
      lat_cnt_q       <= lat_cnt_d;
      dgrant_cnt_q    <= dgrant_cnt_d;
      mm_req_info_q   <= mm_req_info_d;
      rsp_cache_id_q  <= rsp_cache_id_d;
      rsp_data_q      <= rsp_data_d;
      rsp_bus_error_q <= rsp_bus_error_d;
    end
  end

  assign mm_req_valid_o  = (state_q == S_ISSUE);
  assign mm_req_info_o   = mm_req_info_q;
  assign rsp_valid_o     = (state_q == S_RESP);
  assign rsp_cache_id_o  = rsp_cache_id_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_bus_error_o = rsp_bus_error_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter

module tb_mem_req_arbiter;

  localparam int LW = 32;
  localparam int AW = 32;
  localparam int RW = AW + 1 + LW;

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_req_valid;
  logic [RW-1:0] icache_req_info;
  logic          dcache_req_valid;
  logic [RW-1:0] dcache_req_info;
  logic          mm_req_valid;
  logic [RW-1:0] mm_req_info;
  logic          mm_rsp_valid;
  logic [LW-1:0] mm_rsp_data;
  logic          mm_rsp_bus_error;
  logic          rsp_valid;
  logic          rsp_cache_id;
  logic [LW-1:0] rsp_data;
  logic          rsp_bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .LATENCY_REQ       (2),
    .LINE_WIDTH        (LW),
    .MAX_DCACHE_GRANTS (4),
    .ADDR_WIDTH        (AW)
  ) dut (
    .clock_i            (clk),
    .reset_i            (reset),
    .icache_req_valid_i (icache_req_valid),
    .icache_req_info_i  (icache_req_info),
    .dcache_req_valid_i (dcache_req_valid),
    .dcache_req_info_i  (dcache_req_info),
    .mm_req_valid_o     (mm_req_valid),
    .mm_req_info_o      (mm_req_info),
    .mm_rsp_valid_i     (mm_rsp_valid),
    .mm_rsp_data_i      (mm_rsp_data),
    .mm_rsp_bus_error_i (mm_rsp_bus_error),
    .rsp_valid_o        (rsp_valid),
    .rsp_cache_id_o     (rsp_cache_id),
    .rsp_data_o         (rsp_data),
    .rsp_bus_error_o    (rsp_bus_error)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_info(input logic [AW-1:0] addr, input logic st,
                                            input logic [LW-1:0] data);
    return {addr, st, data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic vi, input logic [RW-1:0] ii, input logic vd, input logic [RW-1:0] di);
    icache_req_valid = vi;
    icache_req_info  = ii;
    dcache_req_valid = vd;
    dcache_req_info  = di;
    step();
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (mm_req_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_eq({tag, "_issue"}, mm_req_valid, 1);
  endtask

  // Wait for issue, check the request, answer one cycle later, check the
  // response, optionally re-request D$ in the response cycle, check hold.
  task automatic serve(input string tag, input logic exp_id, input logic [RW-1:0] exp_info,
                       input logic [LW-1:0] data, input logic err,
                       input logic re_d, input logic [RW-1:0] re_info);
    wait_issue(tag);
    check_eq({tag, "_info"}, mm_req_info, exp_info);
    step();
    check_eq({tag, "_mmv_hold"}, mm_req_valid, 1);
    mm_rsp_valid     = 1'b1;
    mm_rsp_data      = data;
    mm_rsp_bus_error = err;
    step();
    mm_rsp_valid     = 1'b0;
    mm_rsp_data      = '0;
    mm_rsp_bus_error = 1'b0;
    check_eq({tag, "_rspv"}, rsp_valid, 1);
    check_eq({tag, "_id"}, rsp_cache_id, exp_id);
    check_eq({tag, "_data"}, rsp_data, data);
    check_eq({tag, "_err"}, rsp_bus_error, err);
    check_eq({tag, "_mmv_off"}, mm_req_valid, 0);
    if (re_d) begin
      dcache_req_valid = 1'b1;
      dcache_req_info  = re_info;
    end
    step();
    dcache_req_valid = 1'b0;
    check_eq({tag, "_rspv_off"}, rsp_valid, 0);
    check_eq({tag, "_data_held"}, rsp_data, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [RW-1:0] ia;
    logic [RW-1:0] da;

    reset            = 1'b1;
    icache_req_valid = 1'b0;
    icache_req_info  = '0;
    dcache_req_valid = 1'b0;
    dcache_req_info  = '0;
    mm_rsp_valid     = 1'b0;
    mm_rsp_data      = '0;
    mm_rsp_bus_error = 1'b0;

    // Reset for 2 cycles with an I$ pulse that must be ignored
    icache_req_valid = 1'b1;
    icache_req_info  = mk_info(32'h0000_0900, 1'b0, '0);
    step();
    step();
    check_eq("rst_mmv", mm_req_valid, 0);
    check_eq("rst_mminfo", mm_req_info, 0);
    check_eq("rst_rspv", rsp_valid, 0);
    check_eq("rst_id", rsp_cache_id, 0);
    check_eq("rst_data", rsp_data, 0);
    check_eq("rst_err", rsp_bus_error, 0);
    reset            = 1'b0;
    icache_req_valid = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      step();
      seen |= mm_req_valid;
    end
    check_eq("rst_pulse_ignored", seen, 0);
    mm_rsp_valid = 1'b1;
    mm_rsp_data  = 32'hDEAD_BEEF;
    step();
    mm_rsp_valid = 1'b0;
    check_eq("idle_rsp_ignored", rsp_valid, 0);
    step();
    check_eq("idle_rsp_ignored2", rsp_valid, 0);
    check_eq("idle_data_unchanged", rsp_data, 0);

    // D$ load at 0x40 in cycle 0; memory answers in cycle 6
    da = mk_info(32'h0000_0040, 1'b0, '0);
    dcache_req_valid = 1'b1;
    dcache_req_info  = da;
    step();
    dcache_req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check_eq($sformatf("lat_mmv_c%0d", c), mm_req_valid, (c >= 4 && c <= 6));
      check_eq($sformatf("lat_rspv_c%0d", c), rsp_valid, (c == 7));
      if (c == 4) check_eq("lat_info", mm_req_info, da);
      if (c == 7) begin
        check_eq("lat_id", rsp_cache_id, 1);
        check_eq("lat_data", rsp_data, 32'hCAFE_0040);
      end
      mm_rsp_valid = (c == 6);
      mm_rsp_data  = (c == 6) ? 32'hCAFE_0040 : 32'h0;
      step();
    end
    mm_rsp_valid = 1'b0;

    // Simultaneous I$ and D$: D$ first, then I$
    ia = mk_info(32'h0000_0100, 1'b0, '0);
    da = mk_info(32'h0000_0200, 1'b1, 32'h1234_5678);
    pulse(1'b1, ia, 1'b1, da);
    serve("both_d", 1'b1, da, 32'hAAAA_0001, 1'b0, 1'b0, '0);
    serve("both_i", 1'b0, ia, 32'hAAAA_0002, 1'b0, 1'b0, '0);

    // D$ arrives while I$ is in ISSUE: no preemption
    ia = mk_info(32'h0000_0300, 1'b0, '0);
    da = mk_info(32'h0000_0340, 1'b0, '0);
    pulse(1'b1, ia, 1'b0, '0);
    wait_issue("nopre");
    pulse(1'b0, '0, 1'b1, da);
    check_eq("nopre_info", mm_req_info, ia);
    mm_rsp_valid = 1'b1;
    mm_rsp_data  = 32'hBBBB_0001;
    step();
    mm_rsp_valid = 1'b0;
    check_eq("nopre_rspv", rsp_valid, 1);
    check_eq("nopre_id", rsp_cache_id, 0);
    step();
    serve("nopre_d", 1'b1, da, 32'hBBBB_0002, 1'b0, 1'b0, '0);

    // D$ starvation cap: 4 D$ responses then I$
    ia = mk_info(32'h0000_0400, 1'b0, '0);
    da = mk_info(32'h0000_0500, 1'b0, '0);
    pulse(1'b1, ia, 1'b1, da);
    for (int k = 0; k < 4; k++) begin
      serve($sformatf("cap_d%0d", k), 1'b1, mk_info(32'h0000_0500 + 32'(k), 1'b0, '0),
            32'hC000_0000 + 32'(k), 1'b0, 1'b1, mk_info(32'h0000_0501 + 32'(k), 1'b0, '0));
    end
    serve("cap_i", 1'b0, ia, 32'hC000_00FF, 1'b0, 1'b0, '0);
    serve("cap_d_last", 1'b1, mk_info(32'h0000_0504, 1'b0, '0), 32'hC000_0004, 1'b0, 1'b0, '0);

    // Bus error propagated; store acknowledged like a load
    da = mk_info(32'h0000_0600, 1'b1, 32'h5555_AAAA);
    pulse(1'b0, '0, 1'b1, da);
    serve("berr", 1'b1, da, 32'hE000_0001, 1'b1, 1'b0, '0);

    // Reset while in ISSUE discards the request
    ia = mk_info(32'h0000_0700, 1'b0, '0);
    pulse(1'b1, ia, 1'b0, '0);
    wait_issue("rst_issue");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_issue_mmv", mm_req_valid, 0);
    check_eq("rst_issue_err", rsp_bus_error, 0);
    seen = 1'b0;
    repeat (20) begin
      step();
      seen |= (rsp_valid | mm_req_valid);
    end
    check_eq("rst_issue_discard", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
